// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: shared core definitions for the writeback unit.
//   XLEN        datapath width
//   REG_ADDR_W  register address width
//   wb_req_t    writeback request record (destination + data)
//   reg_onehot  register-number to scoreboard-mask helper (x0 never marked)
package wb_unit_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // One-hot mask for a register; x0 maps to an empty mask so it is never pending.
   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
      logic [NUM_REGS-1:0] m;
      m = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous circular-buffer FIFO, async active-low reset.
//   i_clk, i_rst_n     clock / asynchronous active-low reset
//   i_push, i_wdata    write request and data (ignored while full)
//   i_pop              read request (ignored while empty)
//   o_rdata            head entry
//   o_full, o_empty    status flags
//   o_count            occupancy 0..DEPTH
module wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_DEPTH);
   assign o_empty = (r_count == {(PTR_W+1){1'b0}});
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   // Storage and pointers; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WIDTH{1'b0}};
         end
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   // Occupancy; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= {(PTR_W+1){1'b0}};
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: single writer into the register-file write port.
//   i_alu_valid/i_alu_rd/i_alu_result   ALU result (always accepted, priority)
//   i_ld_valid/i_ld_rd/i_ld_data        load return; o_ld_ready = buffer not full
//   i_ld_issue/i_ld_issue_rd            load issued; marks destination pending
//   i_chk_rs1/i_chk_rs2/i_chk_rd        operands of the issuing instruction
//   o_hazard                            any checked register pending (combinational)
//   o_rd/o_result/o_reg_write           registered register-file write port
// Datapath width comes from the core package XLEN.
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_alu_valid,
   input  logic [REG_ADDR_W-1:0] i_alu_rd,
   input  logic [XLEN-1:0]       i_alu_result,
   input  logic                  i_ld_valid,
   output logic                  o_ld_ready,
   input  logic [REG_ADDR_W-1:0] i_ld_rd,
   input  logic [XLEN-1:0]       i_ld_data,
   input  logic                  i_ld_issue,
   input  logic [REG_ADDR_W-1:0] i_ld_issue_rd,
   input  logic [REG_ADDR_W-1:0] i_chk_rs1,
   input  logic [REG_ADDR_W-1:0] i_chk_rs2,
   input  logic [REG_ADDR_W-1:0] i_chk_rd,
   output logic                  o_hazard,
   output logic [REG_ADDR_W-1:0] o_rd,
   output logic [XLEN-1:0]       o_result,
   output logic                  o_reg_write
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

   wb_req_t               w_push_req;
   wb_req_t               w_head;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic [NUM_REGS-1:0]   w_set_mask;
   logic [NUM_REGS-1:0]   w_clr_mask;
   logic [NUM_REGS-1:0]   w_pending_nxt;
   logic [NUM_REGS-1:0]   r_pending;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [XLEN-1:0]       r_result;
   logic                  r_reg_write;

   assign w_push_req.rd   = i_ld_rd;
   assign w_push_req.data = i_ld_data;

   // No pass-through: a full buffer refuses a load even in a cycle it pops.
   assign o_ld_ready = (w_count != CNT_DEPTH);
   assign w_push     = i_ld_valid & ~w_full;
   // Loads drain only in cycles the ALU leaves the write port free.
   assign w_pop      = ~i_alu_valid & ~w_empty;

   wb_fifo #(
      .WIDTH ($bits(wb_req_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_wdata (w_push_req),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Write-port arbitration; address and data hold when nothing is written.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_reg_write <= 1'b0;
         r_rd        <= {REG_ADDR_W{1'b0}};
         r_result    <= {XLEN{1'b0}};
      end else if (i_alu_valid) begin
         r_reg_write <= 1'b1;
         r_rd        <= i_alu_rd;
         r_result    <= i_alu_result;
      end else if (w_pop) begin
         r_reg_write <= 1'b1;
         r_rd        <= w_head.rd;
         r_result    <= w_head.data;
      end else begin
         r_reg_write <= 1'b0;
      end
   end

   // Scoreboard update: clear applied before set so a same-register issue wins.
   always_comb begin
      w_set_mask = {NUM_REGS{1'b0}};
      w_clr_mask = {NUM_REGS{1'b0}};
      if (i_ld_issue) begin
         w_set_mask = reg_onehot(i_ld_issue_rd);
      end else begin
         w_set_mask = {NUM_REGS{1'b0}};
      end
      if (w_pop) begin
         w_clr_mask = reg_onehot(w_head.rd);
      end else begin
         w_clr_mask = {NUM_REGS{1'b0}};
      end
      w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
   end

   // Pending-load scoreboard register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pending <= {NUM_REGS{1'b0}};
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign o_hazard    = r_pending[i_chk_rs1] | r_pending[i_chk_rs2] | r_pending[i_chk_rd];
   assign o_rd        = r_rd;
   assign o_result    = r_result;
   assign o_reg_write = r_reg_write;

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_result;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic [4:0]  chk_rs1, chk_rs2, chk_rd;
   logic        hazard;
   logic [4:0]  rd;
   logic [31:0] result;
   logic        reg_write;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_unit #(.DEPTH(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_result(alu_result),
      .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
      .i_ld_issue(ld_issue), .i_ld_issue_rd(ld_issue_rd),
      .i_chk_rs1(chk_rs1), .i_chk_rs2(chk_rs2), .i_chk_rd(chk_rd),
      .o_hazard(hazard), .o_rd(rd), .o_result(result), .o_reg_write(reg_write)
   );

   typedef struct {
      logic        alu_v;
      logic [4:0]  alu_rd;
      logic [31:0] alu_res;
      logic        ld_v;
      logic [4:0]  ld_rd;
      logic [31:0] ld_dat;
      logic        iss;
      logic [4:0]  iss_rd;
      logic [4:0]  rs1, rs2, crd;
      logic        e_ready, e_haz, e_rw;
      logic [4:0]  e_rd;
      logic [31:0] e_res;
   } vec_t;

   vec_t tbl [14];

   // reference model state
   logic [36:0] mq [$];
   bit          mpend [32];
   logic        m_rw;
   logic [4:0]  m_rd;
   logic [31:0] m_res;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic idle_in();
      alu_valid = 1'b0; alu_rd = 5'd0; alu_result = 32'd0;
      ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
      ld_issue = 1'b0; ld_issue_rd = 5'd0;
      chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int k;
      logic [36:0] ent;
      logic m_ready, m_haz, m_push;

      rst_n = 1'b1;
      idle_in();
      #3 rst_n = 1'b0;
      #1;
      chk("rst_reg_write", reg_write, 1'b0);
      chk("rst_rd", rd, 5'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_ld_ready", ld_ready, 1'b1);
      chk("rst_hazard", hazard, 1'b0);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // ---------------- table-driven directed vectors ----------------
      //          alu_v alu_rd alu_res        ld_v ld_rd ld_dat      iss  iss_rd rs1 rs2 crd  rdy  haz  rw   e_rd  e_res
      tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1234};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h1234};
      tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234};
      tbl[11] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd9, 32'h99,   1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11};
      tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99};
      tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99};

      for (int i = 0; i < 14; i++) begin
         alu_valid = tbl[i].alu_v; alu_rd = tbl[i].alu_rd; alu_result = tbl[i].alu_res;
         ld_valid = tbl[i].ld_v; ld_rd = tbl[i].ld_rd; ld_data = tbl[i].ld_dat;
         ld_issue = tbl[i].iss; ld_issue_rd = tbl[i].iss_rd;
         chk_rs1 = tbl[i].rs1; chk_rs2 = tbl[i].rs2; chk_rd = tbl[i].crd;
         #1;
         chk($sformatf("tbl%0d_ld_ready", i), ld_ready, tbl[i].e_ready);
         chk($sformatf("tbl%0d_hazard", i), hazard, tbl[i].e_haz);
         tick();
         chk($sformatf("tbl%0d_reg_write", i), reg_write, tbl[i].e_rw);
         chk($sformatf("tbl%0d_rd", i), rd, tbl[i].e_rd);
         chk($sformatf("tbl%0d_result", i), result, tbl[i].e_res);
      end
      idle_in();
      tick();

      // ---------------- backpressure under sustained ALU traffic ----------------
      k = 0;
      for (int c = 0; c < 6; c++) begin
         alu_valid = 1'b1; alu_rd = 5'd10; alu_result = 32'(c);
         ld_valid = 1'b1; ld_rd = 5'(11 + k); ld_data = 32'hA0 + 32'(k);
         #1;
         chk($sformatf("bp%0d_ld_ready", c), ld_ready, (c < 4) ? 1'b1 : 1'b0);
         tick();
         if (c < 4) k++;
         chk($sformatf("bp%0d_alu_write", c), {reg_write, rd}, {1'b1, 5'd10});
      end
      alu_valid = 1'b0;
      for (int j = 0; j < 5; j++) begin
         ld_valid = (j < 2) ? 1'b1 : 1'b0;
         #1;
         if (j < 2) chk($sformatf("drain%0d_ld_ready", j), ld_ready, (j == 0) ? 1'b0 : 1'b1);
         tick();
         chk($sformatf("drain%0d_rw", j), reg_write, 1'b1);
         chk($sformatf("drain%0d_rd", j), rd, 5'(11 + j));
         chk($sformatf("drain%0d_result", j), result, 32'hA0 + 32'(j));
      end
      idle_in();
      tick();
      chk("drain_done_rw", reg_write, 1'b0);

      // ---------------- same-register set/clear ----------------
      ld_issue = 1'b1; ld_issue_rd = 5'd3; tick();
      idle_in(); ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33; tick();
      idle_in(); ld_issue = 1'b1; ld_issue_rd = 5'd3; tick();   // pop of first rd3 load
      chk("sr_pop_write", {reg_write, rd, result}, {1'b1, 5'd3, 32'h33});
      idle_in(); chk_rs1 = 5'd3; #1;
      chk("sr_set_wins_hazard", hazard, 1'b1);
      ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h34; tick();
      ld_valid = 1'b0; tick();
      chk("sr_second_write", {reg_write, rd, result}, {1'b1, 5'd3, 32'h34});
      chk("sr_hazard_clear", hazard, 1'b0);
      idle_in(); tick();

      // ---------------- asynchronous reset with buffered loads ----------------
      ld_issue = 1'b1; ld_issue_rd = 5'd20; tick();
      idle_in();
      for (int j = 0; j < 3; j++) begin
         alu_valid = 1'b1; alu_rd = 5'd2; alu_result = 32'h55;
         ld_valid = 1'b1; ld_rd = 5'(21 + j); ld_data = 32'hC0 + 32'(j);
         tick();
      end
      ld_valid = 1'b0; chk_rs1 = 5'd20;
      #1;
      chk("pre_rst_hazard", hazard, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_reg_write", reg_write, 1'b0);
      chk("mid_rst_rd", rd, 5'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_ld_ready", ld_ready, 1'b1);
      chk("mid_rst_hazard", hazard, 1'b0);
      tick();
      idle_in();
      #2 rst_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk($sformatf("post_rst%0d_no_write", j), reg_write, 1'b0);
      end

      // ---------------- randomized run against reference model ----------------
      do_reset();
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      m_rd = 5'd0; m_res = 32'd0; m_rw = 1'b0;
      for (int c = 0; c < 400; c++) begin
         alu_valid   = ($urandom_range(0, 9) < 4);
         alu_rd      = 5'($urandom_range(0, 7));
         alu_result  = $urandom;
         ld_valid    = ($urandom_range(0, 1) == 1);
         ld_rd       = 5'($urandom_range(0, 7));
         ld_data     = $urandom;
         ld_issue    = ($urandom_range(0, 9) < 3);
         ld_issue_rd = 5'($urandom_range(0, 7));
         chk_rs1     = 5'($urandom_range(0, 7));
         chk_rs2     = 5'($urandom_range(0, 7));
         chk_rd      = 5'($urandom_range(0, 7));
         #1;
         m_ready = (mq.size() != 4);
         m_haz   = mpend[chk_rs1] | mpend[chk_rs2] | mpend[chk_rd];
         chk("rnd_ld_ready", ld_ready, m_ready);
         chk("rnd_hazard", hazard, m_haz);
         m_push = ld_valid && m_ready;
         if (alu_valid) begin
            m_rw = 1'b1; m_rd = alu_rd; m_res = alu_result;
         end else if (mq.size() > 0) begin
            ent = mq.pop_front();
            m_rw = 1'b1; m_rd = ent[36:32]; m_res = ent[31:0];
            mpend[m_rd] = 1'b0;
         end else begin
            m_rw = 1'b0;
         end
         if (m_push) mq.push_back({ld_rd, ld_data});
         if (ld_issue && ld_issue_rd != 5'd0) mpend[ld_issue_rd] = 1'b1;
         tick();
         chk("rnd_reg_write", reg_write, m_rw);
         chk("rnd_rd", rd, m_rd);
         chk("rnd_result", result, m_res);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_unit.md
# wb_unit

Writeback unit for the RV32 core: the single writer into the register file's write port (`rd`/`result`/`reg_write`). It merges single-cycle ALU results with variable-latency load returns, buffers load returns in a small FIFO, and serialises them to one register write per cycle. It keeps a pending-load scoreboard that the issue stage queries to stall on RAW and WAW hazards against outstanding loads.

## Interface
- `XLEN`, 32, datapath width.
- `DEPTH`, 4, load-return FIFO entries; power of two, ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `alu_valid` in 1: ALU result valid this cycle; always accepted, no backpressure.
- `alu_rd` in 5: ALU destination register.
- `alu_result` in XLEN: ALU result.
- `ld_valid` in 1: load return valid.
- `ld_ready` out 1: FIFO can accept; `!full`.
- `ld_rd` in 5: load destination register.
- `ld_data` in XLEN: load data.
- `ld_issue` in 1: load issued this cycle; marks `ld_issue_rd` pending.
- `ld_issue_rd` in 5: destination of the issued load.
- `chk_rs1`, `chk_rs2`, `chk_rd` in 5 each: issuing instruction's operands.
- `hazard` out 1: any checked register pending (combinational).
- `rd` out 5: register-file write address.
- `result` out XLEN: register-file write data.
- `reg_write` out 1: register-file write enable.

## Operation
- Load FIFO:
  - A push occurs when `ld_valid && ld_ready`.
  - `ld_ready = (count != DEPTH)`. There is no pass-through, so a full FIFO rejects a load even while it pops.
  - Storage is a circular buffer with wrapping `log2(DEPTH)`-bit read and write pointers and a `0..DEPTH` count.
- Write arbitration, once per cycle; the result is registered into `rd`/`result`/`reg_write`:
  - ALU has priority. If `alu_valid`, then `reg_write<=1`, `rd<=alu_rd`, `result<=alu_result`.
  - Otherwise, if the FIFO is not empty, pop the head and drive its `rd`/data with `reg_write<=1`.
  - Otherwise `reg_write<=0`; `rd` and `result` hold their previous values.
  - An arbitrated write with rd==0 is still presented. The register file ignores it.
  - A popped load clears its pending bit.
- Scoreboard: 32-bit `pending` vector.
  - Set on `ld_issue` when `ld_issue_rd != 0`.
  - Cleared in the cycle a popped load entry is registered onto the write port, i.e. while its `reg_write` is high.
  - If set and clear target the same register in the same cycle, set wins.
  - Bit 0 is constant 0.
- Hazard: `hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]`.
  - `pending[0]=0`, so x0 operands never stall.
- Issue guarantees an ALU write never targets a pending register. The block does not check this.

## Timing
- Reset values:
  - `rd=0`, `result=0`, `reg_write=0`, `pending=0`.
  - FIFO empty: pointers 0, count 0, so `ld_ready=1` and `hazard=0`.
- Reset asserted mid-operation drops all buffered loads and pending bits immediately (asynchronous).
- ALU latency: `alu_valid` in cycle N gives `reg_write` high in cycle N+1, and the register-file write lands at the end of N+1.
- Load latency: minimum 2 cycles. A push in N allows a pop at the N+1 edge, so `reg_write` is high in N+2 if the ALU is idle in N+1.
  - Each ALU-valid cycle delays pops by one cycle.
- Simultaneous push and pop with count between 1 and DEPTH-1: count unchanged.
- The pending bit is cleared by the same edge that raises `reg_write` for that load. `hazard` drops in the cycle the register file's write-bypass makes the value readable.
- Sustained ALU traffic can starve the FIFO. When the FIFO is full, `ld_ready=0` backpressures the load unit.

## Structure
- Shared core package holds:
  - `XLEN`.
  - `REG_ADDR_W=5`.
  - the writeback-request record (rd + data).
- One sub-module, `wb_fifo`: parameterised sync FIFO with async active-low reset and push/pop/full/empty/count.
- Arbitration, output registers and scoreboard live in `wb_unit`.

## Test plan
- Reset, then idle: `reg_write=0`, `rd=0`, `result=0`, `ld_ready=1`, `hazard=0`.
- `alu_valid`, rd=5, 0xDEADBEEF in cycle 1: cycle 2 `reg_write=1`, rd=5, result=0xDEADBEEF; cycle 3 `reg_write=0`.
- Load flow:
  - `ld_issue` rd=7, then `chk_rs1=7`: `hazard=1`.
  - Load return rd=7, 0x1234 with the ALU idle: write presented 2 cycles later.
  - `hazard=0` in that same cycle.
- Continuous `alu_valid` while 5 loads arrive (DEPTH=4):
  - `ld_ready=0` after 4 pushes and the 5th is held.
  - After the ALU stops, 4 writes occur on consecutive cycles in FIFO order, then the 5th is accepted.
- `ld_issue` rd=0: `hazard` stays 0 for `chk_rs1=0`.
- Same-register set/clear: `ld_issue` rd=3 in the same cycle the prior rd=3 load is popped → `pending[3]` stays 1.
- Assert `rst_n` low with 3 entries buffered: outputs return to reset values at once, and no stale write occurs after release.
